mips_div_unit: RTL and testbench

//  Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EXE stage.

---
 rtl/mips_div_unit.sv | 155 +++++++++++++++
 tb/tb_mips_div_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mips_div_unit
//  Description : Iterative radix-2 restoring divider for MIPS DIV/DIVU.
//                Optional macro DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvs;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;

    logic                 w_dvd_neg;
    logic                 w_dvs_neg;
    logic [WIDTH-1:0]     w_dvd_abs;
    logic [WIDTH-1:0]     w_dvs_abs;
    logic                 w_early;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH-1:0]     w_q_final;
    logic [WIDTH-1:0]     w_r_final;

    // Magnitudes wrap in WIDTH bits, so the most-negative value stays 100..0 as unsigned.
    assign w_dvd_neg = div_signed & dividend[WIDTH-1];
    assign w_dvs_neg = div_signed & divisor[WIDTH-1];
    assign w_dvd_abs = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_abs = w_dvs_neg ? -divisor  : divisor;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (divisor != '0) && (w_dvd_abs < w_dvs_abs);
`else
    assign w_early = 1'b0;
`endif

    // r_quo shifts dividend bits out at the top while quotient bits enter at the bottom.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_q_final = r_neg_q ? -r_quo : r_quo;
    assign w_r_final = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        quotient  = r_quotient;
        remainder = r_remainder;
        case (r_state)
            S_IDLE: begin
                if (div_start && !flush) begin
                    w_next = w_early ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_count == c_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
                if (!flush) begin
                    done      = 1'b1;
                    quotient  = w_q_final;
                    remainder = w_r_final;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_start && !flush) begin
                        r_count <= '0;
                        r_dvs   <= w_dvs_abs;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_quo   <= w_early ? '0 : w_dvd_abs;
                        r_rem   <= w_early ? w_dvd_abs : '0;
                    end
                end
                S_CALC: begin
                    r_count <= r_count + c_CNT_W'(1);
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                end
                S_DONE: begin
                    if (!flush) begin
                        r_quotient  <= w_q_final;
                        r_remainder <= w_r_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_div_unit.sv
`default_nettype none
// Testbench for mips_div_unit: directed cases plus randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_mips_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    mips_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_signed (div_signed),
        .flush      (flush),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural result of DIV/DIVU, including the divide-by-zero and overflow rules.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (!s) begin
            if (b == 0) begin q = '1; r = a; end
            else begin q = a / b; r = a % b; end
        end else if (b == 0) begin
            q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {q, r};
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
        return (s && x[31]) ? -x : x;
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (EARLY && b != 0 && mag(a, s) < mag(b, s)) return 1;
        return 33;
    endfunction

    // Reference model: pending op, cycles remaining until done, held results.
    bit          m_pending = 1'b0;
    int          m_left    = 0;
    logic [31:0] m_q = '0, m_r = '0, m_hq = '0, m_hr = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_pending = 1'b0;
            m_left    = 0;
            m_hq      = '0;
            m_hr      = '0;
        end else if (m_pending) begin
            if (flush) m_pending = 1'b0;
            else if (m_left == 0) begin
                m_hq      = m_q;
                m_hr      = m_r;
                m_pending = 1'b0;
            end else m_left--;
        end else if (div_start && !flush) begin
            {m_q, m_r} = ref_div(dividend, divisor, div_signed);
            m_left     = ref_lat(dividend, divisor, div_signed) - 1;
            m_pending  = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic exp_done;
        if (!rst) begin
            exp_done = m_pending && (m_left == 0) && !flush;
            chk("busy", {31'd0, busy}, {31'd0, m_pending});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            chk("quotient", quotient, exp_done ? m_q : m_hq);
            chk("remainder", remainder, exp_done ? m_r : m_hr);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input int elat);
        int n;
        bit seen;
        @(posedge clk); #1;
        dividend = a; divisor = b; div_signed = s; div_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0;
        n = 1;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            @(posedge clk);
            n++;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL op_timeout: no done for %h/%h within 100 cycles", a, b);
        end else begin
            chk("latency", n, elat);
            chk("op_q", quotient, eq);
            chk("op_r", remainder, er);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Model pins against hand-computed values.
        chk("ref_divu", ref_div(32'd100, 32'd7, 1'b0)[63:32], 32'h0000_000E);
        chk("ref_div_neg", ref_div(-32'd7, 32'd2, 1'b1)[31:0], 32'hFFFF_FFFF);
        chk("ref_div_zero_s", ref_div(-32'd5, 32'd0, 1'b1)[63:32], 32'd1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);

        run_op(32'd100, 32'd7, 1'b0, 32'h0000_000E, 32'h0000_0002, 33);
        run_op(-32'd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 33);
        run_op(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 33);
        run_op(32'd3, 32'd10, 1'b0, 32'd0, 32'd3, EARLY ? 1 : 33);

        // Flush in CALC cycle 10 together with a competing start.
        @(posedge clk); #1;
        dividend = 32'd1000; divisor = 32'd3; div_signed = 1'b0; div_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; div_start = 1'b1; dividend = 32'd5; divisor = 32'd1;
        @(posedge clk); #1;
        flush = 1'b0; div_start = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_q", quotient, 32'd0);
        chk("flush_r", remainder, 32'd3);
        repeat (40) @(posedge clk);
        run_op(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 33);

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        dividend = 32'd77; divisor = 32'd5; div_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_q", quotient, 32'd0);

        for (int c = 0; c < 8000; c++) begin
            @(posedge clk); #1;
            div_start  = ($urandom_range(0, 9) < 3);
            flush      = ($urandom_range(0, 99) < 2);
            div_signed = $urandom_range(0, 1) == 1;
            dividend   = pick();
            divisor    = pick();
        end
        @(posedge clk); #1;
        div_start = 1'b0;
        flush     = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
